// File: rtl/isp_dram_fetch.sv
// isp_dram_fetch: fetches one 32x32 RGB picture over AXI4 read bursts and re-emits it as tagged 128-bit beats.
// Optional protocol checking on the R channel is enabled by defining ISP_FETCH_ERR_CHECK_EN.
module isp_dram_fetch #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned PIC_BYTES   = 3072,
  parameter int unsigned BURST_BEATS = 192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  input  logic [3:0]   start_pic_no,
  output logic         busy,
  output logic         done,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [127:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic         pix_valid,
  output logic [127:0] pix_data,
  output logic [1:0]   pix_ch,
  output logic [4:0]   pix_row,
  output logic         pix_half,
  output logic         pix_last,
  input  logic         pix_ready,
  output logic         err
);

  localparam int unsigned CNT_W       = 8;
  localparam int unsigned TOTAL_BEATS = PIC_BYTES / 16;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_BEATS * 16);
  localparam logic [CNT_W-1:0] LAST_LOCAL = CNT_W'(BURST_BEATS - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(TOTAL_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] local_cnt;
  logic             r_hs;
  logic             pix_hs;
  logic             burst_end;

  assign arlen   = 8'(BURST_BEATS - 1);
  assign arsize  = 3'b100;
  assign arburst = 2'b01;

  // R beats are taken whenever the one-entry buffer is empty or draining this cycle
  assign rready    = (state == S_R) && (!pix_valid || pix_ready);
  assign r_hs      = rvalid && rready;
  assign pix_hs    = pix_valid && pix_ready;
  assign burst_end = (local_cnt == LAST_LOCAL);

  // Fetch sequencer: address phase, data phase, drain of the last buffered beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      beat_cnt  <= '0;
      local_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_valid && !done) begin
            araddr    <= BASE_ADDR + 32'(start_pic_no) * 32'(PIC_BYTES);
            beat_cnt  <= '0;
            local_cnt <= '0;
            busy      <= 1'b1;
            arvalid   <= 1'b1;
            state     <= S_AR;
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            beat_cnt  <= beat_cnt + CNT_W'(1);
            local_cnt <= burst_end ? '0 : local_cnt + CNT_W'(1);
            if (burst_end) begin
              if (beat_cnt == LAST_BEAT) begin
                state <= S_DRAIN;
              end else begin
                araddr  <= araddr + BURST_BYTES;
                arvalid <= 1'b1;
                state   <= S_AR;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!pix_valid || pix_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-entry output buffer; tags derive from the picture-wide beat index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_ch    <= '0;
      pix_row   <= '0;
      pix_half  <= 1'b0;
      pix_last  <= 1'b0;
    end else if (r_hs) begin
      pix_valid <= 1'b1;
      pix_data  <= rdata;
      pix_ch    <= beat_cnt[7:6];
      pix_row   <= beat_cnt[5:1];
      pix_half  <= beat_cnt[0];
      pix_last  <= (beat_cnt == LAST_BEAT);
    end else if (pix_hs) begin
      pix_valid <= 1'b0;
    end
  end

`ifdef ISP_FETCH_ERR_CHECK_EN
  // Sticky flag for error responses or rlast out of step with the beat count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (r_hs && ((rresp != 2'b00) || (rlast != burst_end))) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_rsp;
  assign unused_rsp = ^{rresp, rlast};
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_isp_dram_fetch.sv
// Scoreboard bench for isp_dram_fetch: two instances (192- and 48-beat bursts) fed by pseudo-DRAM slave models.
module tb_isp_dram_fetch;

  localparam int unsigned PIC_BYTES = 3072;
  localparam logic [31:0] BASE      = 32'h0001_0000;
  localparam int          TIMEOUT   = 6000;

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   ch;
    logic [4:0]   row;
    logic         half;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic [3:0]   start_pic_no = 4'd0;
  logic         pix_ready;

  logic         busy[2], done[2], arvalid[2], arready[2], rlast[2], rvalid[2], rready[2];
  logic         pix_valid[2], pix_half[2], pix_last[2], err[2];
  logic [31:0]  araddr[2];
  logic [7:0]   arlen[2];
  logic [2:0]   arsize[2];
  logic [1:0]   arburst[2], rresp[2], pix_ch[2];
  logic [127:0] rdata[2], pix_data[2];
  logic [4:0]   pix_row[2];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    ideal = 1'b1;
  bit    inject = 1'b0;
  bit    err_exp = 1'b0;
  bit    done_seen[2];
  int    acc_cnt[2];
  int    exp_sum[2];
  int    act_sum[2];
  beat_t exp_q[2][$];
  logic [31:0] ar_q[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [191:0] act, input logic [191:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, inst, act, expv);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    return 8'(a * 32'd7) ^ a[15:8];
  endfunction

  function automatic beat_t exp_beat(input int pic, input int b);
    beat_t e;
    logic [31:0] a;
    a = BASE + 32'(pic) * 32'(PIC_BYTES) + 32'(b) * 32'd16;
    for (int k = 0; k < 16; k++) e.data[k*8 +: 8] = byte_at(a + 32'(k));
    e.ch   = 2'(b / 64);
    e.row  = 5'((b % 64) / 2);
    e.half = (b % 2) == 1;
    e.last = (b == 191);
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ideal ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned BB = (g == 0) ? 192 : 48;

    isp_dram_fetch #(.BURST_BEATS(BB)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_pic_no(start_pic_no),
      .busy(busy[g]), .done(done[g]), .araddr(araddr[g]), .arlen(arlen[g]), .arsize(arsize[g]),
      .arburst(arburst[g]), .arvalid(arvalid[g]), .arready(arready[g]), .rdata(rdata[g]),
      .rresp(rresp[g]), .rlast(rlast[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .pix_valid(pix_valid[g]), .pix_data(pix_data[g]), .pix_ch(pix_ch[g]), .pix_row(pix_row[g]),
      .pix_half(pix_half[g]), .pix_last(pix_last[g]), .pix_ready(pix_ready), .err(err[g])
    );

    // Pseudo-DRAM slave: one burst at a time, optional random AR/R gaps
    initial begin : slave
      bit act, ar_hs, r_hs;
      logic [31:0] addr;
      int cnt, gbeat;
      act = 0; cnt = 0; gbeat = 0; addr = '0;
      arready[g] = 1'b0; rvalid[g] = 1'b0; rdata[g] = '0; rresp[g] = 2'b00; rlast[g] = 1'b0;
      forever begin
        @(negedge clk);
        ar_hs = rst_n && arvalid[g] && arready[g];
        r_hs  = rst_n && rvalid[g] && rready[g];
        if (ar_hs) begin
          addr = araddr[g];
          chk("ar_expected", g, 192'(ar_q[g].size() > 0), 192'(1));
          if (ar_q[g].size() > 0) chk("araddr", g, 192'(araddr[g]), 192'(ar_q[g].pop_front()));
          chk("ar_fields", g, 192'({arlen[g], arsize[g], arburst[g]}), 192'({8'(BB - 1), 3'b100, 2'b01}));
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
          act = 0; cnt = 0; gbeat = 0;
          arready[g] = 1'b0; rvalid[g] = 1'b0; rresp[g] = 2'b00; rlast[g] = 1'b0;
          continue;
        end
        if (!busy[g]) gbeat = 0;
        if (ar_hs) begin
          act = 1;
          cnt = 0;
        end
        if (r_hs) begin
          cnt++;
          gbeat++;
          if (cnt == int'(BB)) act = 0;
        end
        arready[g] = !act && (ideal || ($urandom_range(0, 1) == 1));
        if (act) begin
          if (!(rvalid[g] && !r_hs)) rvalid[g] = ideal ? 1'b1 : 1'($urandom_range(0, 1));
          for (int k = 0; k < 16; k++) rdata[g][k*8 +: 8] = byte_at(addr + 32'(cnt * 16 + k));
          rlast[g] = (cnt == int'(BB) - 1);
          rresp[g] = (inject && gbeat == 5) ? 2'b10 : 2'b00;
        end else begin
          rvalid[g] = 1'b0;
          rlast[g]  = 1'b0;
          rresp[g]  = 2'b00;
        end
      end
    end

    // Output monitor: pops the scoreboard on every accepted beat
    initial begin : mon
      beat_t cur, prev, e;
      bit stalled;
      int last_acc;
      stalled = 0; last_acc = 0; prev = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          stalled = 0;
          continue;
        end
        cur.data = pix_data[g]; cur.ch = pix_ch[g]; cur.row = pix_row[g];
        cur.half = pix_half[g]; cur.last = pix_last[g];
        if (stalled) chk("stall_hold", g, 192'({pix_valid[g], cur}), 192'({1'b1, prev}));
        stalled = pix_valid[g] && !pix_ready;
        prev = cur;
        if (pix_valid[g] && pix_ready) begin
          chk("err_timing", g, 192'(err[g]), 192'(err_exp && acc_cnt[g] >= 5));
          chk("beat_expected", g, 192'(exp_q[g].size() > 0), 192'(1));
          if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            chk("beat", g, 192'(cur), 192'(e));
          end
          for (int k = 0; k < 16; k++) act_sum[g] += int'(cur.data[k*8 +: 8]);
          acc_cnt[g]++;
          last_acc = cyc;
        end
        if (done[g]) begin
          chk("done_latency", g, 192'(cyc), 192'(last_acc + 1));
          chk("byte_sum", g, 192'(act_sum[g]), 192'(exp_sum[g]));
          chk("beats_left", g, 192'(exp_q[g].size()), 192'(0));
          done_seen[g] = 1'b1;
        end
      end
    end
  end

  task automatic chk_zero(input string name);
    for (int g = 0; g < 2; g++)
      chk(name, g, 192'({busy[g], done[g], arvalid[g], rready[g], pix_valid[g], pix_data[g], pix_ch[g],
                         pix_row[g], pix_half[g], pix_last[g], araddr[g], err[g]}), '0);
  endtask

  task automatic flush;
    for (int g = 0; g < 2; g++) begin
      exp_q[g].delete();
      ar_q[g].delete();
    end
  endtask

  task automatic launch(input int pic, input logic [31:0] a0);
    for (int g = 0; g < 2; g++) begin
      int bb;
      beat_t e;
      bb = (g == 0) ? 192 : 48;
      for (int k = 0; k < 192 / bb; k++) ar_q[g].push_back(a0 + 32'(k * bb * 16));
      exp_sum[g] = 0; act_sum[g] = 0; acc_cnt[g] = 0; done_seen[g] = 1'b0;
      for (int b = 0; b < 192; b++) begin
        e = exp_beat(pic, b);
        exp_q[g].push_back(e);
        for (int k = 0; k < 16; k++) exp_sum[g] += int'(e.data[k*8 +: 8]);
      end
    end
    start_pic_no = 4'(pic);
    start_valid  = 1'b1;
    tick(1);
    start_valid  = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("ar_after_start", g, 192'({arvalid[g], busy[g]}), 192'(2'b11));
  endtask

  task automatic wait_done(input bit chaos);
    int n;
    n = 0;
    while (!(done_seen[0] && done_seen[1]) && n < TIMEOUT) begin
      tick(1);
      n++;
      start_valid  = chaos && busy[0] && busy[1] && ($urandom_range(0, 3) == 0);
      start_pic_no = 4'($urandom_range(0, 15));
    end
    start_valid = 1'b0;
    chk("done_seen", 0, 192'({done_seen[0], done_seen[1]}), 192'(2'b11));
    tick(4);
    for (int g = 0; g < 2; g++)
      chk("idle_after", g, 192'({busy[g], arvalid[g], pix_valid[g], 32'(ar_q[g].size()), 32'(exp_q[g].size())}), '0);
    flush();
  endtask

  initial begin
    int n;
    tick(2);
    @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    tick(2);

    ideal = 1'b1;
    launch(0, 32'h0001_0000);  wait_done(1'b0);
    launch(15, 32'h0001_B400); wait_done(1'b0);
    launch(3, 32'h0001_2400);  wait_done(1'b0);

    ideal = 1'b0;
    launch(7, 32'h0001_5400);  wait_done(1'b0);
    launch(9, 32'h0001_6C00);  wait_done(1'b1);

    launch(5, 32'h0001_3C00);
    n = 0;
    while (acc_cnt[0] < 100 && n < TIMEOUT) begin
      tick(1);
      n++;
    end
    chk("beat100_reached", 0, 192'(acc_cnt[0] >= 100), 192'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset_outputs");
    tick(3);
    flush();
    rst_n = 1'b1;
    tick(2);
    launch(2, 32'h0001_1800); wait_done(1'b0);

    ideal  = 1'b1;
    inject = 1'b1;
`ifdef ISP_FETCH_ERR_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    launch(4, 32'h0001_3000); wait_done(1'b0);
    for (int g = 0; g < 2; g++) chk("err_held", g, 192'(err[g]), 192'(err_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
